// File: rtl/irq_scheduler.sv
// -----------------------------------------------------------------------------
// irq_scheduler
//
// Interrupt scheduler with one programmable periodic timer (channel 0) and
// NUM_SRC rising-edge external request channels (channels 1..NUM_SRC).
// Every channel has a vector, a mask bit and a pending bit. Fixed priority
// (lowest index wins) picks the channel to deliver. Delivery is a req/ack
// handshake with the control unit, and it is held off while r_k is non-zero.
//
// Ports
//   clock        in   single clock, all state on posedge
//   init_flag    in   asynchronous active-low reset
//   r_k          in   kernel register; non-zero blocks new delivery
//   SCHED_ENB    in   scheduler instruction valid
//   SCHED_conf   in   config instruction (ops need ENB and conf both high)
//   SCHED_OP     in   opcode
//   SCHED_sel    in   channel select, values above NUM_SRC make a no-op
//   SCHED_value  in   operand
//   src_req      in   external requests, rising-edge sensitive
//   int_ack      in   control unit accepted the current interrupt
//   int_req      out  interrupt request
//   int_pos      out  vector of the requested channel
//   int_id       out  channel being requested
//   sys_int_pos  out  syscall jump position
//   timer_int    out  timer pending bit
//   pending      out  raw pending bits
// -----------------------------------------------------------------------------
module irq_scheduler #(
    parameter int NUM_SRC        = 4,
    parameter int TIMER_WIDTH    = 32,
    parameter int DEFAULT_PERIOD = 50000000
) (
    input  logic                 clock,
    input  logic                 init_flag,
    input  logic [15:0]          r_k,
    input  logic                 SCHED_ENB,
    input  logic                 SCHED_conf,
    input  logic [3:0]           SCHED_OP,
    input  logic [3:0]           SCHED_sel,
    input  logic [15:0]          SCHED_value,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic                 int_ack,
    output logic                 int_req,
    output logic [15:0]          int_pos,
    output logic [3:0]           int_id,
    output logic [15:0]          sys_int_pos,
    output logic                 timer_int,
    output logic [NUM_SRC:0]     pending
);

    localparam logic [3:0] OP_SYS   = 4'b0001;
    localparam logic [3:0] OP_VEC   = 4'b0010;
    localparam logic [3:0] OP_PLO   = 4'b0011;
    localparam logic [3:0] OP_PHI   = 4'b0100;
    localparam logic [3:0] OP_EN    = 4'b0101;
    localparam logic [3:0] OP_DIS   = 4'b0110;
    localparam logic [3:0] OP_TRST  = 4'b0111;
    localparam logic [3:0] OP_MASK  = 4'b1000;
    localparam logic [3:0] OP_CLR   = 4'b1001;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_REQ   = 1'b1;

    localparam logic [TIMER_WIDTH-1:0] PERIOD_RST = TIMER_WIDTH'(DEFAULT_PERIOD);
    localparam logic [TIMER_WIDTH-1:0] ONE        = TIMER_WIDTH'(1);

    logic [15:0]            r_sys_int_pos;
    logic [15:0]            r_vec [NUM_SRC+1];
    logic [TIMER_WIDTH-1:0] r_period;
    logic [TIMER_WIDTH-1:0] r_count;
    logic [NUM_SRC:0]       r_mask;
    logic [NUM_SRC:0]       r_pend;
    logic [NUM_SRC-1:0]     r_src_prev;
    logic                   r_gen;
    logic [0:0]             r_state;
    logic                   r_int_req;
    logic [3:0]             r_int_id;
    logic [15:0]            r_int_pos;

    logic                   w_cfg;
    logic [NUM_SRC:0]       w_sel_hit;
    logic                   w_timer_run;
    logic                   w_expire;
    logic                   w_ack;
    logic [NUM_SRC:0]       w_set;
    logic [NUM_SRC:0]       w_clr;
    logic [NUM_SRC:0]       w_pend_nxt;
    logic [NUM_SRC:0]       w_eligible;
    logic [3:0]             w_winner;
    logic [15:0]            w_win_vec;

    assign w_cfg       = SCHED_ENB & SCHED_conf;
    assign w_timer_run = r_gen && (r_period != '0);
    // The >= compare lets a period shrunk below the current count wrap at once.
    assign w_expire    = w_timer_run && (r_count >= r_period - ONE);
    assign w_ack       = (r_state == ST_REQ) && int_ack;
    assign w_set       = {src_req & ~r_src_prev, w_expire};
    assign w_eligible  = r_pend & r_mask;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_sel_hit  = '0;
        w_clr      = '0;
        w_winner   = '0;
        w_win_vec  = '0;
        for (int i = 0; i <= NUM_SRC; i++) begin
            // Select values above NUM_SRC hit no channel, so the op is a no-op.
            w_sel_hit[i] = w_cfg && (SCHED_sel == 4'(i));
            w_clr[i]     = (w_ack && (r_int_id == 4'(i))) ||
                           (w_sel_hit[i] && (SCHED_OP == OP_CLR));
        end
        // Descending scan so the lowest eligible index is the last to write.
        for (int i = NUM_SRC; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 4'(i);
            end
        end
        for (int i = 0; i <= NUM_SRC; i++) begin
            if (w_winner == 4'(i)) begin
                w_win_vec = r_vec[i];
            end
        end
    end

    // A set event beats any clear, except that a timer reset beats expiry.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i <= NUM_SRC; i++) begin
            if (w_set[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_clr[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
        if (w_cfg && (SCHED_OP == OP_TRST)) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            r_sys_int_pos <= '0;
            r_period      <= PERIOD_RST;
            r_count       <= '0;
            r_mask        <= '1;
            r_gen         <= 1'b0;
            // NOTE: the vector table is small and must read back as zero after
            // reset, so it is reset like ordinary flops rather than left as RAM.
            for (int i = 0; i <= NUM_SRC; i++) begin
                r_vec[i] <= '0;
            end
        end else begin
            if (w_cfg && (SCHED_OP == OP_SYS)) r_sys_int_pos <= SCHED_value;
            if (w_cfg && (SCHED_OP == OP_PLO)) r_period[15:0] <= SCHED_value;
            if (w_cfg && (SCHED_OP == OP_PHI)) begin
                r_period[TIMER_WIDTH-1:16] <= SCHED_value[TIMER_WIDTH-17:0];
            end
            if (w_cfg && (SCHED_OP == OP_EN))  r_gen <= 1'b1;
            if (w_cfg && (SCHED_OP == OP_DIS)) r_gen <= 1'b0;
            for (int i = 0; i <= NUM_SRC; i++) begin
                if (w_sel_hit[i] && (SCHED_OP == OP_VEC))  r_vec[i]  <= SCHED_value;
                if (w_sel_hit[i] && (SCHED_OP == OP_MASK)) r_mask[i] <= SCHED_value[0];
            end
            if (w_cfg && (SCHED_OP == OP_TRST)) begin
                r_count <= '0;
            end else if (w_expire) begin
                r_count <= '0;
            end else if (w_timer_run) begin
                r_count <= r_count + ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            r_pend     <= '0;
            r_src_prev <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_src_prev <= src_req;
        end
    end

    // Once in REQ the request is frozen; only int_ack (or reset) ends it.
    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            r_state   <= ST_IDLE;
            r_int_req <= 1'b0;
            r_int_id  <= '0;
            r_int_pos <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_gen && (r_k == 16'h0000) && (|w_eligible)) begin
                        r_state   <= ST_REQ;
                        r_int_req <= 1'b1;
                        r_int_id  <= w_winner;
                        r_int_pos <= w_win_vec;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_state   <= ST_IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign int_req     = r_int_req;
    assign int_pos     = r_int_pos;
    assign int_id      = r_int_id;
    assign sys_int_pos = r_sys_int_pos;
    assign timer_int   = r_pend[0];
    assign pending     = r_pend;

endmodule
